// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder (with full_adder bit-slice)
// Brief    : Bit-serial WIDTH-bit adder, LSB first, one full_adder per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int                c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_s;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    full_adder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_last     = (r_count == c_LAST);
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next_state = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand shifters, carry flop, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_count <= '0;
                    end
                end
                S_SHIFT: begin
                    r_res   <= w_res_next;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry <= w_cout;
                    if (w_last) begin
                        // Publish the finished word, including this cycle's bit
                        r_sum   <= w_res_next;
                        r_cout  <= w_cout;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed self-checking bench for serial_adder with a latency model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted request yields a+b+cin exactly WIDTH edges later
    logic             m_busy, m_done, m_cout, chk_en;
    logic [WIDTH-1:0] m_sum;
    logic [WIDTH:0]   m_pending;
    int               m_rem;

    initial chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_rem = 0;
            chk_en = 1'b1;
        end else if (m_rem == 0) begin
            m_done = 1'b0;
            if (start) begin
                m_pending = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                m_rem  = WIDTH;
                m_busy = 1'b1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                {m_cout, m_sum} = m_pending;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== m_busy || done !== m_done || sum !== m_sum || cout !== m_cout) begin
                errors++;
                $display("FAIL cycle_compare: got busy=%b done=%b sum=%h cout=%b, want busy=%b done=%b sum=%h cout=%b",
                         busy, done, sum, cout, m_busy, m_done, m_sum, m_cout);
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Launch one addition, wait for done, check result and busy length
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input string name);
        int  nb;
        bit  got;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (busy) nb++;
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check_val({name, "_done_seen"}, {31'b0, got}, 32'd1);
        check_val({name, "_sum"}, {24'b0, sum}, {24'b0, es});
        check_val({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
        check_val({name, "_busy_cycles"}, nb, WIDTH);
        @(negedge clk);
    endtask

    int dcount;

    initial begin
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0;
        // Reset dominates a pending start
        repeat (2) @(negedge clk);
        check_val("reset_busy", {31'b0, busy}, 32'd0);
        check_val("reset_done", {31'b0, done}, 32'd0);
        check_val("reset_sum",  {24'b0, sum},  32'd0);
        check_val("reset_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_val("idle_after_reset", {31'b0, busy}, 32'd0);

        run_op(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_out");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "max_cin");

        // Operand change and start pulses while busy are ignored
        @(negedge clk);
        a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("hold_prior_sum", {24'b0, sum}, 32'hFF);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dcount++;
                check_val("ignore_sum", {24'b0, sum}, 32'h96);
                check_val("ignore_cout", {31'b0, cout}, 32'd0);
            end
            @(negedge clk);
        end
        check_val("ignore_done_count", dcount, 1);

        // Back-to-back with start held high
        a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                check_val("b2b_sum", {24'b0, sum}, 32'h03);
                check_val("b2b_cout", {31'b0, cout}, 32'd0);
            end
        end
        check_val("b2b_done_count", dcount, 3);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in mid-operation aborts it
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", {31'b0, busy}, 32'd0);
        check_val("abort_sum",  {24'b0, sum},  32'd0);
        check_val("abort_cout", {31'b0, cout}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check_val("abort_no_done", dcount, 0);

        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_abort");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around one instance of the existing full_adder cell (ports a, b, cin, s, cout). Operands are latched on a start request. One bit is added per clock, LSB first, with the carry held in a flip-flop. The block is the sequential consumer of the full_adder bit-slice and trades WIDTH cycles of latency for a single adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request a new addition; sampled only when busy=0
a      input   WIDTH  operand A, latched when start is accepted
b      input   WIDTH  operand B, latched when start is accepted
cin    input   1      carry-in, latched when start is accepted
busy   output  1      high while an addition is in progress
done   output  1      one-cycle pulse: sum/cout just updated
sum    output  WIDTH  result of last completed addition
cout   output  1      carry-out of last completed addition

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge), taking priority over everything:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 -> latch a, b into shift regs, carry<=cin, count<=0, go to SHIFT. Otherwise stay.
  - SHIFT: each edge feeds LSBs of the A/B shift regs plus the carry flop into full_adder.
    - s is shifted into the MSB of the internal result reg; both operand regs shift right one bit; carry<=cout.
    - count increments; on the edge where count==WIDTH-1, go to DONE.
  - DONE: lasts exactly one cycle.
    - Entered with sum<=final result reg, cout<=final carry, done=1.
    - Next edge: start=1 behaves as in IDLE (immediate relaunch, back-to-back); start=0 goes to IDLE.
- busy=1 exactly in SHIFT. done=1 exactly in DONE.
- Latency: start accepted at edge k -> done=1 and new sum/cout visible in the cycle following edge k+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- sum/cout change only on the edge entering DONE (or reset). They hold the previous result throughout SHIFT.
- start while busy=1 is ignored and not queued.
- Changes on a, b, cin after acceptance have no effect on the in-flight operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Counter sized to hold 0..WIDTH-1. No wrap-around beyond WIDTH-1 occurs.
- Reset mid-operation aborts the addition: no done pulse, and outputs return to reset values.

Test Plan:
1. rst=1 for 2 cycles with start=1 and a=8'hFF -> busy=0, done=0, sum=8'h00, cout=0; no operation starts.
2. a=8'h00, b=8'h01, cin=0, start pulse at edge k -> busy high 8 cycles; done pulse in the cycle after edge k+8; sum=8'h01, cout=0.
3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
4. a=8'h3C, b=8'h5A, cin=0 start, then change a=8'hFF and pulse start during busy -> exactly one done pulse; sum=8'h96, cout=0; sum remains at the prior value until done.
5. Start held high continuously with a=8'h01, b=8'h01, cin=1 -> done every 9 cycles; sum=8'h03, cout=0 each time; busy low only in done cycles.
6. Start a=8'h80, b=8'h80; assert rst after 3 shift cycles -> busy=0, no done pulse, sum=0, cout=0. Then new start a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1.
